// File: rtl/mult_calc_ctrl_if.sv
// ============================================================================
// Module   : mult_calc_ctrl_if
// Brief    : Keypad strobe and LED/status bundle for the calculator controller.
// Revision : 1.0
// ============================================================================
`default_nettype none

interface mult_calc_ctrl_if #(
  parameter int WIDTH = 4
);
  logic               key_valid;
  logic [3:0]         keycode;
  logic [2*WIDTH-1:0] led;
  logic               busy;
  logic               done;
  logic [1:0]         state;

  modport master (
    output key_valid,
    output keycode,
    input  led,
    input  busy,
    input  done,
    input  state
  );

  modport slave (
    input  key_valid,
    input  keycode,
    output led,
    output busy,
    output done,
    output state
  );
endinterface

`default_nettype wire

// File: rtl/mult_calc_ctrl.sv
// ============================================================================
// Module   : mult_calc_ctrl
// Brief    : Keypad calculator controller with a sequential shift-add multiplier.
// Revision : 1.0
// ============================================================================
`default_nettype none

module mult_calc_ctrl #(
  parameter int WIDTH     = 4,
  parameter int KEY_ENTER = 10,
  parameter int KEY_CLEAR = 11
) (
  input  wire logic          CLOCK_50,
  input  wire logic          reset_n,
  mult_calc_ctrl_if.slave    bus
);

  localparam int         CNT_W       = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [3:0] c_key_enter = 4'(KEY_ENTER);
  localparam logic [3:0] c_key_clear = 4'(KEY_CLEAR);

  typedef enum logic [1:0] {
    S_ENTER_A = 2'd0,
    S_ENTER_B = 2'd1,
    S_MUL     = 2'd2,
    S_SHOW    = 2'd3
  } state_t;

  state_t               state_q,  state_d;
  logic [WIDTH-1:0]     a_q,      a_d;
  logic [WIDTH-1:0]     b_q,      b_d;
  logic                 tens_q,   tens_d;
  logic [WIDTH-1:0]     mcand_q,  mcand_d;
  logic [WIDTH-1:0]     mplier_q, mplier_d;
  logic [2*WIDTH-1:0]   acc_q,    acc_d;
  logic [CNT_W-1:0]     cnt_q,    cnt_d;
  logic [2*WIDTH-1:0]   led_q,    led_d;
  logic                 done_q,   done_d;

  logic                 w_key_digit;
  logic                 w_key_enter;
  logic                 w_key_clear;
  logic [WIDTH-1:0]     w_digit;
  logic [WIDTH-1:0]     w_entry_val;
  logic                 w_entry_tens;
  logic [WIDTH:0]       w_sum;
  logic [2*WIDTH-1:0]   w_acc_step;

  assign w_key_digit = bus.key_valid && (bus.keycode <= 4'd9);
  assign w_key_enter = bus.key_valid && (bus.keycode == c_key_enter);
  assign w_key_clear = bus.key_valid && (bus.keycode == c_key_clear);
  assign w_digit     = WIDTH'(bus.keycode);

  // A leading '1' arms the tens position; a following 0..5 forms 10..15,
  // anything larger simply replaces the operand.
  always_comb begin
    w_entry_val  = w_digit;
    w_entry_tens = 1'b0;
    if (!tens_q) begin
      if (bus.keycode == 4'd1) w_entry_tens = 1'b1;
    end else if (bus.keycode <= 4'd5) begin
      w_entry_val = WIDTH'(10) + w_digit;
    end
  end

  // Single WIDTH-bit adder on the upper accumulator half, then shift right.
  assign w_sum      = {1'b0, acc_q[2*WIDTH-1:WIDTH]}
                    + {1'b0, (mplier_q[0] ? mcand_q : {WIDTH{1'b0}})};
  assign w_acc_step = {w_sum, acc_q[WIDTH-1:1]};

  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    tens_d   = tens_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    led_d    = led_q;
    done_d   = 1'b0;

    if (w_key_clear) begin
      state_d = S_ENTER_A;
      a_d     = '0;
      b_d     = '0;
      tens_d  = 1'b0;
      led_d   = '0;
    end else begin
      case (state_q)
        S_ENTER_A: begin
          if (w_key_digit) begin
            a_d    = w_entry_val;
            tens_d = w_entry_tens;
            led_d  = {w_entry_val, b_q};
          end else if (w_key_enter) begin
            state_d = S_ENTER_B;
            tens_d  = 1'b0;
          end
        end
        S_ENTER_B: begin
          if (w_key_digit) begin
            b_d    = w_entry_val;
            tens_d = w_entry_tens;
            led_d  = {a_q, w_entry_val};
          end else if (w_key_enter) begin
            state_d  = S_MUL;
            mcand_d  = a_q;
            mplier_d = b_q;
            acc_d    = '0;
            cnt_d    = '0;
            tens_d   = 1'b0;
          end
        end
        S_MUL: begin
          acc_d    = w_acc_step;
          mplier_d = mplier_q >> 1;
          cnt_d    = cnt_q + 1'b1;
          if (cnt_q == CNT_W'(WIDTH-1)) begin
            state_d = S_SHOW;
            led_d   = w_acc_step;
            done_d  = 1'b1;
          end
        end
        default: begin
        end
      endcase
    end
  end

  always_ff @(posedge CLOCK_50 or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= S_ENTER_A;
      a_q      <= '0;
      b_q      <= '0;
      tens_q   <= 1'b0;
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
      led_q    <= '0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      tens_q   <= tens_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      led_q    <= led_d;
      done_q   <= done_d;
    end
  end

  assign bus.led   = led_q;
  assign bus.busy  = (state_q == S_MUL);
  assign bus.done  = done_q;
  assign bus.state = state_q;

endmodule

`default_nettype wire

// File: tb/tb_mult_calc_ctrl.sv
// ============================================================================
// Module   : tb_mult_calc_ctrl
// Brief    : Directed self-checking bench for the keypad calculator controller.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_mult_calc_ctrl;

  localparam logic [3:0] c_enter = 4'd10;
  localparam logic [3:0] c_clear = 4'd11;

  logic CLOCK_50;
  logic reset_n;
  int   errors;
  int   checks;

  mult_calc_ctrl_if #(.WIDTH(4)) bus ();

  mult_calc_ctrl #(
    .WIDTH     (4),
    .KEY_ENTER (10),
    .KEY_CLEAR (11)
  ) dut (
    .CLOCK_50 (CLOCK_50),
    .reset_n  (reset_n),
    .bus      (bus)
  );

  initial CLOCK_50 = 1'b0;
  always #5 CLOCK_50 = ~CLOCK_50;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One-cycle strobe; returns at the negedge following the sampling edge.
  task automatic press(input logic [3:0] k);
    @(negedge CLOCK_50);
    bus.key_valid = 1'b1;
    bus.keycode   = k;
    @(negedge CLOCK_50);
    bus.key_valid = 1'b0;
  endtask

  // Call right after the ENTER that starts MUL returns (cycle t+1).
  task automatic run_mul(input string tag, input logic [7:0] prod);
    for (int i = 0; i < 4; i++) begin
      chk({tag, " busy"}, {31'd0, bus.busy}, 32'd1);
      chk({tag, " done early"}, {31'd0, bus.done}, 32'd0);
      @(negedge CLOCK_50);
    end
    chk({tag, " done"}, {31'd0, bus.done}, 32'd1);
    chk({tag, " led"}, {24'd0, bus.led}, {24'd0, prod});
    chk({tag, " state"}, {30'd0, bus.state}, 32'd3);
    chk({tag, " busy off"}, {31'd0, bus.busy}, 32'd0);
    @(negedge CLOCK_50);
    chk({tag, " done pulse"}, {31'd0, bus.done}, 32'd0);
    chk({tag, " led hold"}, {24'd0, bus.led}, {24'd0, prod});
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    errors        = 0;
    checks        = 0;
    reset_n       = 1'b0;
    bus.key_valid = 1'b0;
    bus.keycode   = 4'd0;
    repeat (2) @(negedge CLOCK_50);
    chk("reset led",   {24'd0, bus.led},   32'd0);
    chk("reset busy",  {31'd0, bus.busy},  32'd0);
    chk("reset done",  {31'd0, bus.done},  32'd0);
    chk("reset state", {30'd0, bus.state}, 32'd0);
    reset_n = 1'b1;

    // 3 x 5
    press(4'd3);
    chk("t1 A=3", {24'd0, bus.led}, 32'h30);
    press(c_enter);
    chk("t1 state B", {30'd0, bus.state}, 32'd1);
    press(4'd5);
    chk("t1 led 35", {24'd0, bus.led}, 32'h35);
    press(c_enter);
    chk("t1 state MUL", {30'd0, bus.state}, 32'd2);
    run_mul("t1", 8'h0F);

    // 15 x 15
    press(c_clear);
    chk("t2 clear state", {30'd0, bus.state}, 32'd0);
    chk("t2 clear led",   {24'd0, bus.led},   32'd0);
    press(4'd1);
    chk("t2 A=1", {24'd0, bus.led}, 32'h10);
    press(4'd5);
    chk("t2 A=15", {24'd0, bus.led}, 32'hF0);
    press(c_enter);
    press(4'd1);
    press(4'd5);
    chk("t2 led FF", {24'd0, bus.led}, 32'hFF);
    press(c_enter);
    run_mul("t2", 8'hE1);

    // tens handling
    press(c_clear);
    press(4'd1);
    press(4'd7);
    chk("t3 A=7", {24'd0, bus.led}, 32'h70);
    press(4'd1);
    press(4'd1);
    chk("t3 A=11", {24'd0, bus.led}, 32'hB0);
    press(4'd2);
    chk("t3 tens cleared", {24'd0, bus.led}, 32'h20);

    // ignored codes and key_valid gating
    press(4'd12);
    chk("ign 12 led", {24'd0, bus.led}, 32'h20);
    press(4'd15);
    chk("ign 15 state", {30'd0, bus.state}, 32'd0);
    @(negedge CLOCK_50);
    bus.keycode = c_enter;
    @(negedge CLOCK_50);
    chk("no valid state", {30'd0, bus.state}, 32'd0);

    // clear two cycles into MUL
    press(c_enter);
    press(4'd3);
    chk("t4 led 23", {24'd0, bus.led}, 32'h23);
    press(c_enter);
    chk("t4 busy", {31'd0, bus.busy}, 32'd1);
    press(c_clear);
    chk("t4 state", {30'd0, bus.state}, 32'd0);
    chk("t4 led",   {24'd0, bus.led},   32'd0);
    chk("t4 busy off", {31'd0, bus.busy}, 32'd0);
    for (int i = 0; i < 4; i++) begin
      chk("t4 no done", {31'd0, bus.done}, 32'd0);
      @(negedge CLOCK_50);
    end
    chk("t4 still A", {30'd0, bus.state}, 32'd0);

    // keys during MUL and SHOW: 6 x 7
    press(4'd6);
    press(c_enter);
    press(4'd7);
    chk("t5 led 67", {24'd0, bus.led}, 32'h67);
    press(c_enter);
    bus.key_valid = 1'b1;
    bus.keycode   = 4'd9;
    @(negedge CLOCK_50);
    bus.keycode   = c_enter;
    @(negedge CLOCK_50);
    bus.keycode   = 4'd5;
    @(negedge CLOCK_50);
    bus.key_valid = 1'b0;
    chk("t5 busy", {31'd0, bus.busy}, 32'd1);
    @(negedge CLOCK_50);
    chk("t5 done",  {31'd0, bus.done},  32'd1);
    chk("t5 led",   {24'd0, bus.led},   32'h2A);
    chk("t5 state", {30'd0, bus.state}, 32'd3);
    press(4'd8);
    press(c_enter);
    chk("t5 show led",   {24'd0, bus.led},   32'h2A);
    chk("t5 show state", {30'd0, bus.state}, 32'd3);
    press(c_clear);
    chk("t5 clear state", {30'd0, bus.state}, 32'd0);

    // async reset mid-MUL
    press(4'd2);
    press(c_enter);
    press(4'd4);
    press(c_enter);
    #2;
    reset_n = 1'b0;
    #1;
    chk("t6 led",   {24'd0, bus.led},   32'd0);
    chk("t6 busy",  {31'd0, bus.busy},  32'd0);
    chk("t6 state", {30'd0, bus.state}, 32'd0);
    chk("t6 done",  {31'd0, bus.done},  32'd0);
    @(negedge CLOCK_50);
    reset_n = 1'b1;
    press(4'd9);
    chk("t6 A=9", {24'd0, bus.led}, 32'h90);
    press(c_enter);
    press(4'd3);
    chk("t6 led 93", {24'd0, bus.led}, 32'h93);
    press(c_enter);
    run_mul("t6", 8'h1B);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
